// File: rtl/pio_out_multi_if.sv
// Avalon-MM slave bus bundle for pio_out_multi.
//   address    : register select (0 DATA, 1 MODE, 2 SET, 3 CLEAR)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data, WIDTH bits
//   readdata   : read data, WIDTH bits, combinational from address
// Handshake: a write is accepted on every posedge clk where
// chipselect=1 and write_n=0; there is no waitrequest, so reads and
// writes always complete with zero wait states.
interface pio_out_multi_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_out_multi.sv
// Multi-bit output port for the sell-machine system. Each bit is either a
// plain latch (level mode) or a self-clearing pulse of PULSE_CYCLES clocks
// (pulse mode). SET/CLEAR registers give atomic per-bit updates.
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : Avalon-MM slave (see pio_out_multi_if)
//   out_port   : registered output lines
//   pulse_busy : bit=1 while that bit's pulse timer is running
module pio_out_multi #(
  parameter int          WIDTH        = 8,
  parameter int          PULSE_CYCLES = 50,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter logic [31:0] RESET_MODE   = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_out_multi_if.slave    bus,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  pulse_busy
);

  localparam int               CW       = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(PULSE_CYCLES);
  localparam logic [WIDTH-1:0] RST_OUT  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_MODE = RESET_MODE[WIDTH-1:0];

  logic [WIDTH-1:0] mode;
  logic [CW-1:0]    cnt [WIDTH];

  logic             wr;
  logic             wr_mode;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] affect;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_mode = wr && (bus.address == 2'd1);

  // Requested next value and which bits the write actually touches.
  // DATA touches every bit; SET/CLEAR touch only bits written as 1.
  always_comb begin
    nxt    = out_port;
    affect = '0;
    if (wr) begin
      unique case (bus.address)
        2'd0: begin
          nxt    = bus.writedata;
          affect = '1;
        end
        2'd2: begin
          nxt    = out_port | bus.writedata;
          affect = bus.writedata;
        end
        2'd3: begin
          nxt    = out_port & ~bus.writedata;
          affect = bus.writedata;
        end
        default: begin
          nxt    = out_port;
          affect = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RST_OUT;
      mode     <= RST_MODE;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      if (wr_mode) mode <= bus.writedata;
      for (int i = 0; i < WIDTH; i++) begin
        if (mode[i]) begin
          if (wr_mode && !bus.writedata[i]) begin
            // Leaving pulse mode: stop the timer, freeze the output as-is.
            cnt[i] <= '0;
          end else if (affect[i]) begin
            // A touching write beats expiry; a 1 always restarts the timer.
            if (nxt[i]) begin
              cnt[i]      <= CNT_LOAD;
              out_port[i] <= 1'b1;
            end else begin
              cnt[i]      <= '0;
              out_port[i] <= 1'b0;
            end
          end else if (cnt[i] == CW'(1)) begin
            cnt[i]      <= '0;
            out_port[i] <= 1'b0;
          end else if (cnt[i] != '0) begin
            cnt[i] <= cnt[i] - CW'(1);
          end
        end else begin
          out_port[i] <= nxt[i];
          cnt[i]      <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) pulse_busy[i] = (cnt[i] != '0);
  end

  always_comb begin
    unique case (bus.address)
      2'd0:    bus.readdata = out_port;
      2'd1:    bus.readdata = mode;
      2'd2:    bus.readdata = pulse_busy;
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_multi.sv
// Bench for pio_out_multi: directed scenarios plus random bus traffic.
// The reference model tracks each bit as a static value OR-ed with a
// pulse that is high while the cycle count is below a deadline.
module tb_pio_out_multi;
  localparam int          W  = 8;
  localparam int          P  = 4;
  localparam logic [31:0] RV = 32'h5A;
  localparam logic [31:0] RM = 32'h80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pio_out_multi_if #(.WIDTH(W)) bus ();
  logic [W-1:0] out_port;
  logic [W-1:0] pulse_busy;

  pio_out_multi #(
    .WIDTH(W), .PULSE_CYCLES(P), .RESET_VALUE(RV), .RESET_MODE(RM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .out_port(out_port), .pulse_busy(pulse_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [3*W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [W-1:0] m_mode;
  logic [W-1:0] m_static;
  longint       m_dl [W];
  longint       t = 0;

  function automatic logic [W-1:0] m_busy();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (t < m_dl[i]);
    return r;
  endfunction

  function automatic logic [W-1:0] m_out();
    return m_static | m_busy();
  endfunction

  function automatic logic [W-1:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_out();
      2'd1:    return m_mode;
      2'd2:    return m_busy();
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode   = RM[W-1:0];
    m_static = RV[W-1:0];
    for (int i = 0; i < W; i++) m_dl[i] = 0;
  endtask

  task automatic model_step(input logic cs, input logic wn,
                            input logic [1:0] a, input logic [W-1:0] wd);
    logic [W-1:0] cur;
    logic [W-1:0] n;
    logic         wr;
    cur = m_out();
    n   = cur;
    wr  = cs && !wn;
    if (wr && a == 2'd0) n = wd;
    if (wr && a == 2'd2) n = cur | wd;
    if (wr && a == 2'd3) n = cur & ~wd;
    t++;
    for (int i = 0; i < W; i++) begin
      if (m_mode[i]) begin
        if (wr && a == 2'd1 && !wd[i]) begin
          m_static[i] = cur[i];
          m_dl[i]     = 0;
        end else if (wr && (a == 2'd0 || ((a == 2'd2 || a == 2'd3) && wd[i]))) begin
          m_static[i] = 1'b0;
          m_dl[i]     = n[i] ? t + P : 0;
        end
      end else begin
        m_static[i] = n[i];
        m_dl[i]     = 0;
      end
    end
    if (wr && a == 2'd1) m_mode = wd;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic cs, input logic wn,
                       input logic [1:0] a, input logic [W-1:0] wd);
    @(negedge clk);
    #1;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    @(posedge clk);
    #1;
    model_step(cs, wn, a, wd);
    exp_q.push_back({m_out(), m_busy(), m_rd(a)});
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] wd);
    cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), W'($urandom));
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd1;
    #1;
    model_reset();
    chk("reset_out", out_port, RV[W-1:0]);
    chk("reset_mode_rd", bus.readdata, RM[W-1:0]);
    chk("reset_busy", pulse_busy, '0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [3*W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_out_port", out_port, e[3*W-1:2*W]);
        chk("sb_pulse_busy", pulse_busy, e[2*W-1:W]);
        chk("sb_readdata", bus.readdata, e[W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hc;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Level mode sequence
    wr(2'd1, 8'h00);
    wr(2'd0, 8'hA5); chk("level_data", out_port, 8'hA5);
    wr(2'd2, 8'h0A); chk("level_set", out_port, 8'hAF);
    wr(2'd3, 8'h21); chk("level_clear", out_port, 8'h8E);
    cycle(1'b0, 1'b1, 2'd0, 8'h00); chk("level_read0", bus.readdata, 8'h8E);

    // Single pulse: high for exactly P cycles
    wr(2'd1, 8'h01);
    hc = 0;
    for (int j = 0; j < P + 3; j++) begin
      if (j == 0) wr(2'd2, 8'h01); else idle();
      hc += int'(out_port[0]);
    end
    chk("pulse_width", 8'(hc), 8'(P));

    // Retrigger at k+3 -> high through k+6
    hc = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 0 || j == 3) wr(2'd2, 8'h01); else idle();
      hc += int'(out_port[0]);
    end
    chk("retrigger_width", 8'(hc), 8'(P + 3));

    // Abort with CLEAR
    wr(2'd2, 8'h01); idle(); idle();
    wr(2'd3, 8'h01);
    chk("abort_out0", {7'd0, out_port[0]}, 8'h00);
    chk("abort_busy0", {7'd0, pulse_busy[0]}, 8'h00);

    // Write in the expiry cycle extends without a gap
    hc = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 0) wr(2'd2, 8'h01);
      else if (j == P) wr(2'd0, 8'h01);
      else idle();
      hc += int'(out_port[0]);
    end
    chk("collision_width", 8'(hc), 8'(2 * P));

    // Mode switch mid-pulse freezes the bit high
    wr(2'd2, 8'h01); idle();
    wr(2'd1, 8'h00);
    chk("modesw_out0", {7'd0, out_port[0]}, 8'h01);
    chk("modesw_busy0", {7'd0, pulse_busy[0]}, 8'h00);
    repeat (P + 1) idle();
    chk("modesw_hold", {7'd0, out_port[0]}, 8'h01);

    // Reset mid-pulse
    wr(2'd1, 8'h01); wr(2'd2, 8'h01); idle();
    do_reset();

    // Random traffic
    for (int j = 0; j < 400; j++) begin
      if (j == 200) do_reset();
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), W'($urandom));
    end

    repeat (3) idle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
